// File: rtl/ana_bellek_denetleyici.sv
`timescale 1ns/1ps
// Main memory controller: turns single-word requests into SRAM accesses and
// returns read data through a credit-protected response FIFO. Accesses that
// fall outside the SRAM window never reach the SRAM and raise a sticky error.
module ana_bellek_denetleyici #(
    parameter int          ADRES_BIT      = 14,
    parameter int          YANIT_DERINLIK = 4,
    parameter logic [31:0] BELLEK_TABAN   = 32'h4000_0000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          mem_istek_adres_i,
    input  logic [31:0]          mem_istek_veri_i,
    input  logic                 mem_istek_yaz_i,
    input  logic                 mem_istek_gecerli_i,
    output logic                 mem_istek_hazir_o,
    output logic [31:0]          mem_veri_o,
    output logic                 mem_veri_gecerli_o,
    input  logic                 mem_veri_hazir_i,
    output logic                 sram_etkin_o,
    output logic                 sram_yaz_o,
    output logic [ADRES_BIT-1:0] sram_adres_o,
    output logic [31:0]          sram_veri_o,
    input  logic [31:0]          sram_veri_i,
    output logic                 hata_o
);

    localparam int          PB          = $clog2(YANIT_DERINLIK);
    localparam int          DB          = PB + 1;
    localparam logic [32:0] PENCERE_ALT = {1'b0, BELLEK_TABAN};
    localparam logic [32:0] PENCERE_UST = {1'b0, BELLEK_TABAN} + (33'd4 << ADRES_BIT);

    // Response FIFO storage and bookkeeping
    logic [31:0]          r_fifo [YANIT_DERINLIK];
    logic [PB-1:0]        r_yaz_ptr;
    logic [PB-1:0]        r_oku_ptr;
    logic [DB-1:0]        r_doluluk;
    logic                 r_ucusta;        // a read was issued last cycle
    logic                 r_ucusta_hata;   // ...and it was out of window
    logic                 r_hata;

    logic [DB-1:0]        w_rezerve;
    logic                 w_hazir;
    logic                 w_kabul;
    logic                 w_okuma_kabul;
    logic                 w_pencere;
    logic [31:0]          w_fark;
    logic [ADRES_BIT-1:0] w_kelime;
    logic [31-ADRES_BIT:0] w_unused_fark_bitleri;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_bos_degil;
    logic [31:0]          w_push_veri;

    // Credits count buffered responses plus the one read still in the SRAM
    assign w_rezerve     = r_doluluk + DB'(r_ucusta);
    assign w_hazir       = !rst_i && (w_rezerve < DB'(YANIT_DERINLIK));
    assign w_kabul       = mem_istek_gecerli_i && w_hazir;
    assign w_okuma_kabul = w_kabul && !mem_istek_yaz_i;

    // 33-bit compare so the window end cannot wrap around 2^32
    assign w_pencere = ({1'b0, mem_istek_adres_i} >= PENCERE_ALT) &&
                       ({1'b0, mem_istek_adres_i} <  PENCERE_UST);
    assign w_fark    = mem_istek_adres_i - BELLEK_TABAN;
    assign w_kelime  = w_fark[ADRES_BIT+1:2];
    assign w_unused_fark_bitleri = {w_fark[31:ADRES_BIT+2], w_fark[1:0]};

    assign w_bos_degil = (r_doluluk != '0);
    assign w_push      = r_ucusta;
    assign w_pop       = w_bos_degil && mem_veri_hazir_i;
    assign w_push_veri = r_ucusta_hata ? 32'h0000_0000 : sram_veri_i;

    assign mem_istek_hazir_o  = w_hazir;
    assign mem_veri_gecerli_o = w_bos_degil;
    assign mem_veri_o         = w_bos_degil ? r_fifo[r_oku_ptr] : 32'h0000_0000;
    assign hata_o             = r_hata;

    // SRAM is only touched by an accepted in-window request; idle outputs are zero
    always_comb begin
        sram_etkin_o = 1'b0;
        sram_yaz_o   = 1'b0;
        sram_adres_o = '0;
        sram_veri_o  = 32'h0000_0000;
        if (w_kabul && w_pencere) begin
            sram_etkin_o = 1'b1;
            sram_yaz_o   = mem_istek_yaz_i;
            sram_adres_o = w_kelime;
            sram_veri_o  = mem_istek_veri_i;
        end
    end

    // In-flight tracking, FIFO pointers/occupancy and the sticky error flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ucusta      <= 1'b0;
            r_ucusta_hata <= 1'b0;
            r_hata        <= 1'b0;
            r_yaz_ptr     <= '0;
            r_oku_ptr     <= '0;
            r_doluluk     <= '0;
        end else begin
            r_ucusta      <= w_okuma_kabul;
            r_ucusta_hata <= w_okuma_kabul && !w_pencere;
            if (w_kabul && !w_pencere)
                r_hata <= 1'b1;
            if (w_push)
                r_yaz_ptr <= r_yaz_ptr + PB'(1);
            if (w_pop)
                r_oku_ptr <= r_oku_ptr + PB'(1);
            if (w_push && !w_pop)
                r_doluluk <= r_doluluk + DB'(1);
            else if (!w_push && w_pop)
                r_doluluk <= r_doluluk - DB'(1);
        end
    end

    // FIFO data array; no reset needed because occupancy gates visibility
    always_ff @(posedge clk_i) begin
        if (w_push)
            r_fifo[r_yaz_ptr] <= w_push_veri;
    end

    // Credit gating must make an overflowing push impossible
    a_tasma_yok: assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_push && (r_doluluk == DB'(YANIT_DERINLIK))));

endmodule

// File: tb/tb_ana_bellek_denetleyici.sv
`timescale 1ns/1ps
// Self-checking bench: an SRAM model drives the DUT, and a request-level
// reference (memory image + ordered response queue) predicts every output.
module tb_ana_bellek_denetleyici;

    localparam logic [31:0] TABAN = 32'h4000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] mem_istek_adres_i;
    logic [31:0] mem_istek_veri_i;
    logic        mem_istek_yaz_i;
    logic        mem_istek_gecerli_i;
    logic        mem_istek_hazir_o;
    logic [31:0] mem_veri_o;
    logic        mem_veri_gecerli_o;
    logic        mem_veri_hazir_i;
    logic        sram_etkin_o;
    logic        sram_yaz_o;
    logic [13:0] sram_adres_o;
    logic [31:0] sram_veri_o;
    logic [31:0] sram_veri_i;
    logic        hata_o;

    always #5 clk_i = ~clk_i;

    ana_bellek_denetleyici #(
        .ADRES_BIT(14), .YANIT_DERINLIK(4), .BELLEK_TABAN(TABAN)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .mem_istek_adres_i(mem_istek_adres_i), .mem_istek_veri_i(mem_istek_veri_i),
        .mem_istek_yaz_i(mem_istek_yaz_i), .mem_istek_gecerli_i(mem_istek_gecerli_i),
        .mem_istek_hazir_o(mem_istek_hazir_o), .mem_veri_o(mem_veri_o),
        .mem_veri_gecerli_o(mem_veri_gecerli_o), .mem_veri_hazir_i(mem_veri_hazir_i),
        .sram_etkin_o(sram_etkin_o), .sram_yaz_o(sram_yaz_o),
        .sram_adres_o(sram_adres_o), .sram_veri_o(sram_veri_o),
        .sram_veri_i(sram_veri_i), .hata_o(hata_o)
    );

    // SRAM device: unwritten words read back as their own word index
    logic [31:0] sram_dizi    [16384];
    bit          sram_yazildi [16384];
    always @(posedge clk_i) begin
        if (sram_etkin_o) begin
            if (sram_yaz_o) begin
                sram_dizi[sram_adres_o]    <= sram_veri_o;
                sram_yazildi[sram_adres_o] <= 1'b1;
            end else begin
                sram_veri_i <= sram_yazildi[sram_adres_o] ? sram_dizi[sram_adres_o]
                                                          : {18'd0, sram_adres_o};
            end
        end
    end

    // Reference model state
    typedef struct { logic [31:0] veri; int t; } yanit_t;
    yanit_t      kuyruk[$];
    logic [31:0] model_dizi    [16384];
    bit          model_yazildi [16384];
    bit          exp_hata = 1'b0;
    bit          son_kabul;
    int          son_kabul_cyc;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    function automatic bit pencerede(logic [31:0] a);
        longint x;
        x = longint'(a);
        return (x >= 64'h4000_0000) && (x < 64'h4000_0000 + 64'd65536);
    endfunction

    function automatic logic [13:0] kelime(logic [31:0] a);
        logic [31:0] f;
        f = a - TABAN;
        return f[15:2];
    endfunction

    function automatic logic [31:0] model_oku(logic [13:0] k);
        return model_yazildi[k] ? model_dizi[k] : {18'd0, k};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    // One clock: compare everything at the falling edge, then advance the model
    task automatic saat();
        bit          e_hazir, e_gecerli, kabul, inw;
        logic [13:0] k;
        @(negedge clk_i);
        e_hazir   = !rst_i && (kuyruk.size() < 4);
        e_gecerli = !rst_i && (kuyruk.size() > 0) && (kuyruk[0].t + 2 <= cyc);
        chk("hazir", 32'(mem_istek_hazir_o), 32'(e_hazir));
        chk("gecerli", 32'(mem_veri_gecerli_o), 32'(e_gecerli));
        chk("hata", 32'(hata_o), 32'(exp_hata));
        if (e_gecerli)
            chk("veri", mem_veri_o, kuyruk[0].veri);
        else if (rst_i)
            chk("veri_reset", mem_veri_o, 32'h0);
        kabul = mem_istek_gecerli_i && e_hazir;
        inw   = pencerede(mem_istek_adres_i);
        k     = kelime(mem_istek_adres_i);
        chk("sram_etkin", 32'(sram_etkin_o), 32'(kabul && inw));
        chk("sram_yaz", 32'(sram_yaz_o), 32'(kabul && inw && mem_istek_yaz_i));
        chk("sram_adres", 32'(sram_adres_o), (kabul && inw) ? 32'(k) : 32'h0);
        chk("sram_veri", sram_veri_o, (kabul && inw) ? mem_istek_veri_i : 32'h0);
        if (e_gecerli && mem_veri_hazir_i) begin
            $display("yanit  cyc=%0d veri=0x%08h", cyc, kuyruk[0].veri);
            void'(kuyruk.pop_front());
        end
        if (kabul) begin
            $display("istek  cyc=%0d %s adres=0x%08h veri=0x%08h", cyc,
                     mem_istek_yaz_i ? "yaz " : "oku ", mem_istek_adres_i, mem_istek_veri_i);
            if (!inw) exp_hata = 1'b1;
            if (mem_istek_yaz_i) begin
                if (inw) begin
                    model_dizi[k]    = mem_istek_veri_i;
                    model_yazildi[k] = 1'b1;
                end
            end else begin
                kuyruk.push_back('{inw ? model_oku(k) : 32'h0, cyc});
            end
            son_kabul_cyc = cyc;
        end
        son_kabul = kabul;
        cyc++;
        @(posedge clk_i);
        #1;
    endtask

    // Present a request and hold it until accepted (bounded)
    task automatic istek(logic [31:0] a, logic [31:0] d, bit y);
        mem_istek_adres_i   = a;
        mem_istek_veri_i    = d;
        mem_istek_yaz_i     = y;
        mem_istek_gecerli_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            saat();
            if (son_kabul) return;
        end
        checks++;
        failures++;
        $display("FAIL istek_zaman_asimi adres=0x%08h observed=not_accepted expected=accepted_within_40", a);
    endtask

    initial begin
        int bekleme_cyc;
        rst_i = 1'b1;
        mem_istek_adres_i = '0; mem_istek_veri_i = '0;
        mem_istek_yaz_i = 1'b0; mem_istek_gecerli_i = 1'b0;
        mem_veri_hazir_i = 1'b1;
        @(posedge clk_i); #1;
        repeat (2) saat();
        rst_i = 1'b0;
        repeat (2) saat();

        // Write then read the same word back-to-back
        istek(TABAN + 32'h10, 32'h1234_5678, 1'b1);
        istek(TABAN + 32'h10, 32'h0, 1'b0);
        mem_istek_gecerli_i = 1'b0;
        repeat (4) saat();

        // Six reads with the consumer stalled: four credits, then back-pressure
        mem_veri_hazir_i = 1'b0;
        for (int i = 0; i < 4; i++) istek(TABAN + 32'(4 * i), 32'h0, 1'b0);
        mem_istek_adres_i = TABAN + 32'd16;
        repeat (3) saat();
        mem_veri_hazir_i = 1'b1;
        istek(TABAN + 32'd16, 32'h0, 1'b0);
        istek(TABAN + 32'd20, 32'h0, 1'b0);
        mem_istek_gecerli_i = 1'b0;
        repeat (8) saat();

        // Full FIFO, one-cycle pop pulse with a read waiting
        mem_veri_hazir_i = 1'b0;
        for (int i = 10; i < 14; i++) istek(TABAN + 32'(4 * i), 32'h0, 1'b0);
        mem_istek_adres_i = TABAN + 32'd56;
        repeat (3) saat();
        mem_veri_hazir_i = 1'b1;
        bekleme_cyc = cyc;
        saat();
        mem_veri_hazir_i = 1'b0;
        istek(TABAN + 32'd56, 32'h0, 1'b0);
        chk("kredi_donus_cyc", 32'(son_kabul_cyc), 32'(bekleme_cyc + 1));
        mem_istek_gecerli_i = 1'b0;
        mem_veri_hazir_i = 1'b1;
        repeat (8) saat();

        // Out-of-window read and write, then make sure word 0 was not aliased
        istek(32'h3FFF_FFFC, 32'h0, 1'b0);
        istek(32'h4001_0000, 32'hDEAD_BEEF, 1'b1);
        istek(TABAN, 32'h0, 1'b0);
        mem_istek_gecerli_i = 1'b0;
        repeat (5) saat();

        // Asynchronous reset with three buffered responses and one in flight
        mem_veri_hazir_i = 1'b0;
        for (int i = 30; i < 34; i++) istek(TABAN + 32'(4 * i), 32'h0, 1'b0);
        mem_istek_gecerli_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        chk("reset_hazir", 32'(mem_istek_hazir_o), 32'h0);
        chk("reset_gecerli", 32'(mem_veri_gecerli_o), 32'h0);
        chk("reset_hata", 32'(hata_o), 32'h0);
        kuyruk.delete();
        exp_hata = 1'b0;
        @(posedge clk_i); #1;
        saat();
        #2;
        rst_i = 1'b0;
        mem_veri_hazir_i = 1'b1;
        repeat (3) saat();
        istek(TABAN + 32'd200, 32'h0, 1'b0);
        mem_istek_gecerli_i = 1'b0;
        repeat (4) saat();

        // Streaming reads: one accept and one pop per cycle, pointers wrap
        for (int i = 0; i < 20; i++) istek(TABAN + 32'(4 * (40 + i)), 32'h0, 1'b0);
        mem_istek_gecerli_i = 1'b0;
        repeat (6) saat();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            mem_istek_gecerli_i = ($urandom_range(0, 9) < 7);
            mem_istek_yaz_i     = ($urandom_range(0, 9) < 3);
            mem_istek_veri_i    = $urandom;
            if ($urandom_range(0, 15) == 0)
                mem_istek_adres_i = ($urandom_range(0, 1) == 0) ? 32'h3FFF_FFFC
                                                                : 32'h4001_0000 + $urandom_range(0, 255);
            else
                mem_istek_adres_i = TABAN + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
            mem_veri_hazir_i = ($urandom_range(0, 9) < 6);
            saat();
        end
        mem_istek_gecerli_i = 1'b0;
        mem_veri_hazir_i = 1'b1;
        repeat (10) saat();
        chk("kuyruk_bos", 32'(kuyruk.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ana_bellek_denetleyici.md
Name: ana_bellek_denetleyici

Overview:
- Downstream neighbour of the bus controller: consumes its single-word memory request stream (address/data/write, valid/ready) and returns read words over a valid/ready response channel.
- Drives a synchronous single-port SRAM with one-cycle read latency.
- Buffers read responses in a credit-protected FIFO, so the upstream may pipeline several reads before accepting any data without loss.
- Out-of-window accesses are flagged rather than forwarded to the SRAM.

Parameters:
- ADRES_BIT, 14, SRAM word-index width (2^ADRES_BIT words).
- YANIT_DERINLIK, 4, response FIFO depth; power of two, ≥2.
- BELLEK_TABAN, 32'h4000_0000, byte base address of the SRAM window.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- mem_istek_adres_i  in  32  byte address; bits [1:0] ignored.
- mem_istek_veri_i  in  32  write data.
- mem_istek_yaz_i  in  1  1 = write, 0 = read.
- mem_istek_gecerli_i  in  1  request valid.
- mem_istek_hazir_o  out  1  request ready.
- mem_veri_o  out  32  read response data (FIFO head).
- mem_veri_gecerli_o  out  1  response valid.
- mem_veri_hazir_i  in  1  response ready.
- sram_etkin_o  out  1  SRAM enable.
- sram_yaz_o  out  1  SRAM write enable.
- sram_adres_o  out  ADRES_BIT  SRAM word index.
- sram_veri_o  out  32  SRAM write data.
- sram_veri_i  in  32  SRAM read data, valid the cycle after a read enable.
- hata_o  out  1  sticky out-of-window access flag.

Behaviour:
- Reset (async, rst_i=1):
  - FIFO pointers, occupancy, in-flight flag and hata_o clear to 0.
  - mem_veri_gecerli_o=0, mem_veri_o=0, mem_istek_hazir_o=0 while in reset.
  - Responses in flight or buffered are discarded.
- Credits:
  - rezerve = FIFO occupancy + in-flight read (0/1).
  - mem_istek_hazir_o = (rezerve < YANIT_DERINLIK); it never depends on request fields.
  - Writes need ready but consume no credit.
- Accept = mem_istek_gecerli_i && mem_istek_hazir_o in cycle T.
- SRAM drive in cycle T (combinational):
  - sram_etkin_o=1 only for an accepted in-window request; sram_yaz_o=mem_istek_yaz_i.
  - sram_adres_o=(adres-BELLEK_TABAN)>>2, truncated to ADRES_BIT; sram_veri_o=mem_istek_veri_i.
  - All sram outputs inactive (0) otherwise.
- Window: in-window iff BELLEK_TABAN <= adres < BELLEK_TABAN + 4*2^ADRES_BIT, using 33-bit compare with no wrap.
- Out-of-window access:
  - Write: dropped, hata_o set.
  - Read: SRAM not enabled; still consumes a credit; returns 32'h0000_0000; hata_o set.
  - hata_o stays set until reset.
- Read latency:
  - Read accepted at T sets the in-flight flag.
  - At T+1, sram_veri_i (or 0 if out-of-window) is pushed into the FIFO and in-flight clears.
  - mem_veri_gecerli_o is first high at T+2; minimum 2-cycle latency.
  - Back-to-back reads sustain one per cycle while credits remain.
- Response channel:
  - mem_veri_gecerli_o = FIFO non-empty; mem_veri_o = FIFO head.
  - Pop when gecerli && mem_veri_hazir_i.
  - Head data and valid hold stable while hazir_i=0.
- Simultaneous events:
  - Read accept + pop in one cycle: rezerve unchanged.
  - Push + pop in one cycle: occupancy unchanged; a push into an empty FIFO is visible the next cycle only (no bypass).
- Full / empty:
  - Credit gating makes FIFO overflow impossible; an assertion fires if a push occurs with occupancy==YANIT_DERINLIK.
  - Pop on empty cannot occur.
- Pointers: ADRES-independent, $clog2(YANIT_DERINLIK) bits, wrap naturally.
- Ordering: responses return strictly in request order.
  - A write at T followed by a read of the same word at T+1 returns the new data.
  - A read at T and a write of the same word at T+1 returns the old data.

Test Plan:
- Write 0x1234_5678 to 0x4000_0010, then read 0x4000_0010 the next cycle with hazir_i=1 -> sram_adres_o=4 both cycles; mem_veri_o=0x1234_5678 with gecerli high exactly 2 cycles after the read accept.
- Hold hazir_i=0 and issue 6 back-to-back reads to words 0..5 preloaded with value=index -> 4 accepted in consecutive cycles, then hazir_o=0; releasing hazir_i drains 0,1,2,3 then accepts and returns 4,5 in order.
- With FIFO full, pulse hazir_i for one cycle while a new read is pending -> the read is accepted the cycle after the pop, never while rezerve=4; no data lost.
- Read 0x3FFF_FFFC and write 0x4001_0000 (ADRES_BIT=14) -> read returns 0, sram_etkin_o stays 0 for both, hata_o=1 and stays 1 until rst_i pulse.
- Assert rst_i asynchronously mid-clock with 3 responses buffered and 1 in flight -> gecerli_o and hazir_o drop immediately; after release, hazir_o=1 and gecerli_o=0 with no stale responses.
- Alternate accept and pop every cycle for 20 reads at stride 4 bytes -> rezerve constant, pointers wrap ≥4 times, all 20 data match in order.
